parity_check_stream: RTL and testbench

//   Receive-side companion of the XOR-reduction parity generator. Checks a stream
//   of data words, each carrying a transmitted parity bit, through a valid/ready

---
 rtl/parity_check_stream.sv | 127 ++++++++++++
 tb/tb_parity_check_stream.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/parity_check_stream.sv
// Receive-side parity checker behind a single valid/ready register slice.
// Flags per-word and per-frame parity errors, with a saturating error count.
module parity_check_stream #(
  parameter int unsigned width    = 8,
  parameter int unsigned odd      = 0,
  parameter int unsigned cntWidth = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Clr,
  input  logic                InValid,
  output logic                InReady,
  input  logic [width-1:0]    InData,
  input  logic                InPar,
  input  logic                InLast,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [width-1:0]    OutData,
  output logic                OutErr,
  output logic                OutLast,
  output logic                OutFrmErr,
  output logic [cntWidth-1:0] ErrCnt,
  output logic                Sticky
);

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } frm_state_e;

  localparam logic [cntWidth-1:0] CntMax = {cntWidth{1'b1}};
  localparam logic OddSense = (odd != 0);

  frm_state_e state_q, state_d;

  logic                valid_q, valid_d;
  logic [width-1:0]    data_q, data_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  logic                frm_q, frm_d;
  logic                acc_q, acc_d;
  logic [cntWidth-1:0] cnt_q, cnt_d;
  logic                sticky_q, sticky_d;

  logic accept;
  logic beat_err;
  logic acc_cur;

  assign InReady  = !valid_q | OutReady;
  assign accept   = InValid & InReady;
  assign beat_err = (^InData) ^ InPar ^ OddSense;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    err_d    = err_q;
    last_d   = last_q;
    frm_d    = frm_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    acc_cur  = beat_err;

    unique case (state_q)
      FIRST:   acc_cur = beat_err;
      MID:     acc_cur = acc_q | beat_err;
      default: acc_cur = beat_err;
    endcase

    if (accept) begin
      valid_d = 1'b1;
      data_d  = InData;
      err_d   = beat_err;
      last_d  = InLast;
      frm_d   = InLast & acc_cur;
      acc_d   = acc_cur;
      state_d = InLast ? FIRST : MID;
    end else if (OutReady) begin
      valid_d = 1'b0;
    end

    // Clear takes priority over an error counted in the same cycle
    if (Clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (accept && beat_err) begin
      sticky_d = 1'b1;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FIRST;
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      frm_q    <= 1'b0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      last_q   <= last_d;
      frm_q    <= frm_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign OutValid  = valid_q;
  assign OutData   = data_q;
  assign OutErr    = err_q;
  assign OutLast   = last_q;
  assign OutFrmErr = frm_q;
  assign ErrCnt    = cnt_q;
  assign Sticky    = sticky_q;

endmodule

// File: tb/tb_parity_check_stream.sv
// Scoreboard bench for parity_check_stream: directed scenarios plus
// randomized valid/ready traffic checked against a frame-level model.
module tb_parity_check_stream;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int ODD = 0;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic         last;
    logic         frm;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready, in_par, in_last;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready, out_err, out_last, out_frm;
  logic [W-1:0]  out_data;
  logic [CW-1:0] err_cnt;
  logic          sticky;

  int vectors = 0;
  int fails   = 0;

  beat_t exp_q[$];
  int    exp_cnt    = 0;
  bit    exp_sticky = 0;
  bit    frm_bad    = 0;
  bit    mon_en     = 0;

  parity_check_stream #(.width(W), .odd(ODD), .cntWidth(CW)) dut (
    .CLK(clk), .RST(rst), .Clr(clr),
    .InValid(in_valid), .InReady(in_ready),
    .InData(in_data), .InPar(in_par), .InLast(in_last),
    .OutValid(out_valid), .OutReady(out_ready),
    .OutData(out_data), .OutErr(out_err), .OutLast(out_last),
    .OutFrmErr(out_frm), .ErrCnt(err_cnt), .Sticky(sticky)
  );

  always #5 clk = ~clk;

  function automatic bit parity_bad(logic [W-1:0] d, logic p);
    return ((($countones(d) + int'(p)) % 2) != ODD);
  endfunction

  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Called at posedge+2: drive, decide handshake, step model at next edge.
  task automatic cycle(bit v, logic [W-1:0] d, bit p, bit l,
                       bit ordy, bit c, bit r);
    bit acc, e;
    in_valid  = v;
    in_data   = d;
    in_par    = p;
    in_last   = l;
    out_ready = ordy;
    clr       = c;
    rst       = r;
    #2;
    acc = v && in_ready && !r;
    e   = parity_bad(d, p);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_cnt    = 0;
      exp_sticky = 0;
      frm_bad    = 0;
    end else begin
      if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
      if (acc) begin
        beat_t b;
        frm_bad = frm_bad | e;
        b.data = d;
        b.err  = e;
        b.last = l;
        b.frm  = l ? frm_bad : 1'b0;
        if (l) frm_bad = 0;
        exp_q.push_back(b);
      end
      if (c) begin
        exp_cnt    = 0;
        exp_sticky = 0;
      end else if (acc && e) begin
        exp_cnt    = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
        exp_sticky = 1;
      end
    end
    #2;
  endtask

  // Monitor: compare whenever the DUT presents a beat, plus status every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ErrCnt", int'(err_cnt), exp_cnt);
      check("Sticky", int'(sticky), int'(exp_sticky));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("OutData", int'(out_data), int'(exp_q[0].data));
          check("OutErr", int'(out_err), int'(exp_q[0].err));
          check("OutLast", int'(out_last), int'(exp_q[0].last));
          check("OutFrmErr", int'(out_frm), int'(exp_q[0].frm));
        end
      end else begin
        check("lost_beat", exp_q.size(), 0);
      end
      check("InReady", int'(in_ready), int'(!out_valid || out_ready));
    end
  end

  initial begin
    rst = 1; clr = 0; in_valid = 0; in_data = '0;
    in_par = 0; in_last = 0; out_ready = 0;
    @(posedge clk); #2;
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_OutValid", int'(out_valid), 0);
    check("rst_OutData", int'(out_data), 0);
    check("rst_OutErr", int'(out_err), 0);
    check("rst_OutLast", int'(out_last), 0);
    check("rst_OutFrmErr", int'(out_frm), 0);
    check("rst_ErrCnt", int'(err_cnt), 0);
    check("rst_Sticky", int'(sticky), 0);
    check("rst_InReady", int'(in_ready), 1);
    @(posedge clk); #2;
    mon_en = 1;

    // Good then bad single-word frames
    cycle(1, 8'hA5, 0, 1, 1, 0, 0);
    cycle(1, 8'hA4, 0, 1, 1, 0, 0);
    // Three-beat frame, error on middle beat, then clean single word
    cycle(1, 8'h11, 0, 0, 1, 0, 0);
    cycle(1, 8'h13, 0, 0, 1, 0, 0);
    cycle(1, 8'h33, 0, 1, 1, 0, 0);
    cycle(1, 8'h0F, 0, 1, 1, 0, 0);
    // Backpressure with input held valid
    cycle(1, 8'h01, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 8'h02, 1, 1, 0, 0, 0);
    cycle(1, 8'h02, 1, 1, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 0, 0);
    // Saturation, then clear colliding with an error beat
    for (int i = 0; i < 5; i++) cycle(1, 8'h07, 0, 1, 1, 0, 0);
    cycle(1, 8'h07, 0, 1, 1, 1, 0);
    cycle(0, 8'h00, 0, 0, 1, 0, 0);
    // Reset mid-frame after an erroneous first beat
    cycle(1, 8'h01, 0, 0, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 0, 1);
    cycle(1, 8'h03, 0, 1, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), W'($urandom),
            bit'($urandom), bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 40) == 0),
            bit'($urandom_range(0, 300) == 0));
    end
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 1, 0, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
